modrm_sib_encoder: RTL
======================

Name: modrm_sib_encoder

Overview:
- Serialises one decoded 386 addressing form back into instruction bytes: ModR/M, optional SIB, then 0/1/2/4 displacement bytes in little-endian order.
- It is the encode-side counterpart of the front-end ModR/M decoder.
- Used by the self-test instruction injector and the trace re-assembler to rebuild addressing bytes from field-level info.
- Byte stream leaves on a valid/ready interface, one byte per handshake.

Parameters:
- LEN_W, 3, width of enc_len; must hold the maximum value 6.

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous reset, active-high.
- req_valid  in  1  request fields are valid.
- req_ready  out  1  encoder can accept a request.
- req_addr32  in  1  1 = 32-bit addressing, 0 = 16-bit addressing.
- req_mod  in  2  mod field.
- req_reg  in  3  reg/TTT field.
- req_rm  in  3  r/m field.
- req_ss  in  2  SIB scale; ignored when no SIB is emitted.
- req_index  in  3  SIB index; ignored when no SIB is emitted.
- req_base  in  3  SIB base; ignored when no SIB is emitted.
- req_disp  in  32  displacement; low bytes are used according to the displacement length.
- byte_valid  out  1  byte_data is valid.
- byte_ready  in  1  consumer takes the byte.
- byte_data  out  8  current output byte.
- byte_last  out  1  current byte is the final byte of the sequence.
- enc_len  out  LEN_W  total byte count of the current/last sequence.

Behaviour:
- Reset values: req_ready=1, byte_valid=0, byte_data=0, byte_last=0, enc_len=0, state=IDLE.
- States: IDLE, MODRM, SIB, DISP.
- req_ready = (state==IDLE). There is no same-cycle bypass.
- Accept occurs when req_valid & req_ready. All request fields are latched on accept.
- Derived on accept:
  - sib_en = addr32 & mod!=11 & rm==100.
  - disp_len for 16-bit addressing: mod01→1; mod10→2; mod00 & rm110→2; else 0.
  - disp_len for 32-bit addressing: mod01→1; mod10→4; mod00 & rm101→4; mod00 & sib_en & base==101→4; else 0.
  - mod11 → disp_len 0, sib_en 0, in both widths.
  - enc_len = 1 + sib_en + disp_len, registered on accept and held until the next accept.
- Latency: the cycle after accept, state=MODRM, byte_valid=1, byte_data={mod,reg,rm}.
- Byte output rules:
  - byte_data and byte_last stay stable while byte_valid & ~byte_ready.
  - The next byte appears the cycle after a handshake.
  - At most one byte per cycle.
- Transitions on a handshake:
  - MODRM → SIB if sib_en; else → DISP if disp_len≠0; else → IDLE.
  - SIB: byte_data={ss,index,base}. → DISP if disp_len≠0; else → IDLE.
  - DISP: byte_data=disp[8k+7:8k], where byte counter k starts at 0. k increments per handshake; the state leaves to IDLE when k==disp_len-1.
- byte_last=1 exactly on the final byte of the sequence, including a single-byte mod11 sequence.
- After the final handshake, byte_valid deasserts and req_ready asserts on the next cycle. Minimum gap is one idle cycle between sequences.
- Unused displacement bytes are never emitted. Upper disp bits beyond disp_len are ignored.
- rm==100 with mod!=11 in 16-bit mode is [SI]-type addressing: no SIB is emitted.
- Reset asserted mid-sequence:
  - Remaining bytes are discarded.
  - All outputs return to reset values on the next edge.
  - No partial sequence resumes afterwards.
- req_valid while busy is ignored. The requester holds the request until req_ready.

Test Plan:
- addr16, mod=01 reg=010 rm=110 disp=0x000000F8 → bytes 0x56, 0xF8(last); enc_len=2; first byte valid 1 cycle after accept.
- addr16, mod=00 reg=111 rm=110 disp=0x00001234 → 0x3E, 0x34, 0x12(last); enc_len=3.
- addr32, mod=00 reg=000 rm=100 ss=10 index=001 base=101 disp=0x12345678 → 0x04, 0x8D, 0x78, 0x56, 0x34, 0x12(last); enc_len=6.
- mod=11 reg=011 rm=001, addr32=1, ss/index/base/disp random → single byte 0xD9 with byte_last=1; enc_len=1; req_ready high the cycle after handshake.
- Backpressure on the 32-bit case: byte_ready=0 for 3 cycles on byte 0x56 → byte_data held at 0x56, req_ready=0 throughout; order and count unchanged; a second req_valid during this time is not accepted.
- Reset pulse after the 2nd byte of the 6-byte case → next cycle byte_valid=0, req_ready=1, enc_len=0; a new mod=11 request then emits a correct single byte.

Source files
------------

// File: rtl/modrm_sib_encoder.sv
// Rebuilds 386 addressing bytes (ModR/M, optional SIB, little-endian displacement)
// from field-level info and streams them one byte per valid/ready handshake.
module modrm_sib_encoder #(
   parameter int LEN_W = 3
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_addr32,
   input  logic [1:0]       req_mod,
   input  logic [2:0]       req_reg,
   input  logic [2:0]       req_rm,
   input  logic [1:0]       req_ss,
   input  logic [2:0]       req_index,
   input  logic [2:0]       req_base,
   input  logic [31:0]      req_disp,
   output logic             byte_valid,
   input  logic             byte_ready,
   output logic [7:0]       byte_data,
   output logic             byte_last,
   output logic [LEN_W-1:0] enc_len
);

   typedef enum logic [1:0] {IDLE, MODRM, SIB, DISP} state_t;

   state_t      state;
   logic [1:0]  ss_q;
   logic [2:0]  index_q;
   logic [2:0]  base_q;
   logic [31:0] disp_q;
   logic        sib_en_q;
   logic [2:0]  disp_len_q;
   logic [1:0]  k;

   logic        sib_en_c;
   logic [2:0]  disp_len_c;
   logic        accept;
   logic        take;

   function automatic logic [7:0] disp_byte(input logic [31:0] d, input logic [1:0] idx);
      case (idx)
         2'd0:    disp_byte = d[7:0];
         2'd1:    disp_byte = d[15:8];
         2'd2:    disp_byte = d[23:16];
         default: disp_byte = d[31:24];
      endcase
   endfunction

   assign req_ready = (state == IDLE);
   assign accept    = req_valid & req_ready;
   assign take      = byte_valid & byte_ready;

   // In 16-bit mode rm==100 is [SI], so only 32-bit forms carry a SIB byte.
   always_comb begin
      sib_en_c   = req_addr32 && (req_mod != 2'b11) && (req_rm == 3'b100);
      disp_len_c = 3'd0;
      if (req_mod == 2'b01)
         disp_len_c = 3'd1;
      else if (req_mod == 2'b10)
         disp_len_c = req_addr32 ? 3'd4 : 3'd2;
      else if (req_mod == 2'b00) begin
         if (!req_addr32 && req_rm == 3'b110)
            disp_len_c = 3'd2;
         if (req_addr32 && (req_rm == 3'b101 || (sib_en_c && req_base == 3'b101)))
            disp_len_c = 3'd4;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         byte_valid <= 1'b0;
         byte_data  <= 8'h00;
         byte_last  <= 1'b0;
         enc_len    <= '0;
         k          <= 2'd0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  ss_q       <= req_ss;
                  index_q    <= req_index;
                  base_q     <= req_base;
                  disp_q     <= req_disp;
                  sib_en_q   <= sib_en_c;
                  disp_len_q <= disp_len_c;
                  enc_len    <= LEN_W'(4'd1 + 4'(sib_en_c) + 4'(disp_len_c));
                  byte_valid <= 1'b1;
                  byte_data  <= {req_mod, req_reg, req_rm};
                  byte_last  <= !sib_en_c && (disp_len_c == 3'd0);
                  state      <= MODRM;
               end
            end
            MODRM, SIB: begin
               if (take) begin
                  if (state == MODRM && sib_en_q) begin
                     byte_data <= {ss_q, index_q, base_q};
                     byte_last <= (disp_len_q == 3'd0);
                     state     <= SIB;
                  end else if (disp_len_q != 3'd0) begin
                     k         <= 2'd0;
                     byte_data <= disp_byte(disp_q, 2'd0);
                     byte_last <= (disp_len_q == 3'd1);
                     state     <= DISP;
                  end else begin
                     byte_valid <= 1'b0;
                     byte_last  <= 1'b0;
                     state      <= IDLE;
                  end
               end
            end
            DISP: begin
               if (take) begin
                  if ({1'b0, k} == disp_len_q - 3'd1) begin
                     byte_valid <= 1'b0;
                     byte_last  <= 1'b0;
                     state      <= IDLE;
                  end else begin
                     k         <= k + 2'd1;
                     byte_data <= disp_byte(disp_q, k + 2'd1);
                     byte_last <= ({1'b0, k} + 3'd2 == disp_len_q);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
